// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: the PFD state encoding, default counter width,
// and the phase-error sign convention used by the PFD, DCO and loop filter.
package adpll_pkg;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ERR_MAX = 31;

    // err_sign = 1 means the DCO edge came first and the DCO must slow down.
    localparam logic SIGN_DCO_LEADS = 1'b1;
    localparam logic SIGN_DCO_LAGS  = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DCO = 2'd1,
        WAIT_REF = 2'd2
    } pfd_state_e;

endpackage

// File: rtl/pfd_tdc_5bit_if.sv
// Phase-error result bus from the PFD/TDC to the loop filter.
//   err_sign  : 1 = DCO leads, 0 = reference leads or simultaneous
//   err_mag   : clk cycles between leading and trailing edge (saturating)
//   err_valid : one-cycle strobe marking a new err_sign/err_mag
//   lock      : lock indicator (only when PFD_LOCK_DETECT_EN is defined)
// master = PFD (driver), slave = loop filter (consumer).
interface pfd_tdc_5bit_if #(
    parameter int unsigned CNT_W = 5
);
    logic             err_sign;
    logic [CNT_W-1:0] err_mag;
    logic             err_valid;
`ifdef PFD_LOCK_DETECT_EN
    logic             lock;
`endif

    modport master (
        output err_sign,
        output err_mag,
        output err_valid
`ifdef PFD_LOCK_DETECT_EN
        ,
        output lock
`endif
    );

    modport slave (
        input err_sign,
        input err_mag,
        input err_valid
`ifdef PFD_LOCK_DETECT_EN
        ,
        input lock
`endif
    );

endinterface

// File: rtl/sync_edge_det.sv
// SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
//   clk, rst_n : system clock, async active-low reset
//   d_in       : asynchronous input
//   rise_c     : combinational, high for one cycle when the synchronized
//                input is 1 and was 0 on the previous cycle
// SYNC_STAGES must be at least 2.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Shift chain plus one flop of history on the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/pfd_tdc_5bit.sv
// Digital phase/frequency detector and time-to-digital converter.
// Measures the clk-cycle distance between rising edges of ref_in and dco_in
// and reports it as a sign-magnitude error with a one-cycle valid strobe.
//   clk, rst_n : system clock, async active-low reset
//   enable     : measurement enable; low returns the FSM to IDLE
//   ref_in     : reference clock (asynchronous)
//   dco_in     : DCO output (asynchronous)
//   bus        : result bus (err_sign, err_mag, err_valid[, lock])
// Optional macro PFD_LOCK_DETECT_EN adds the lock detector and lock output.
module pfd_tdc_5bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 5
`ifdef PFD_LOCK_DETECT_EN
    ,
    parameter int unsigned LOCK_TOL    = 1,
    parameter int unsigned LOCK_CNT    = 8
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           ref_in,
    input  logic           dco_in,
    pfd_tdc_5bit_if.master bus
);

    import adpll_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             ref_rise_c;
    logic             dco_rise_c;
    pfd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_c;
    logic             res_sign_c;
    logic [CNT_W-1:0] res_mag_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             err_sign_q;
    logic [CNT_W-1:0] err_mag_q;
    logic             err_valid_q;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_in   (ref_in),
        .rise_c (ref_rise_c)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_dco_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_in   (dco_in),
        .rise_c (dco_rise_c)
    );

    // Saturating count-plus-one: also the magnitude when the partner arrives.
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and result event.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_c      = 1'b0;
        res_sign_c = SIGN_DCO_LAGS;
        res_mag_c  = '0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (ref_rise_c && dco_rise_c) begin
                        res_c = 1'b1;
                    end else if (ref_rise_c) begin
                        state_d = WAIT_DCO;
                    end else if (dco_rise_c) begin
                        state_d = WAIT_REF;
                    end
                end
                WAIT_DCO: begin
                    // Partner wins over a recurring leader in the same cycle.
                    if (dco_rise_c) begin
                        res_c     = 1'b1;
                        res_mag_c = cnt_inc_c;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else if (ref_rise_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        res_c     = 1'b1;
                        res_mag_c = CNT_MAX;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                WAIT_REF: begin
                    res_sign_c = SIGN_DCO_LEADS;
                    if (ref_rise_c) begin
                        res_c     = 1'b1;
                        res_mag_c = cnt_inc_c;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else if (dco_rise_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        res_c     = 1'b1;
                        res_mag_c = CNT_MAX;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Result registers: hold between results, strobe for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sign_q  <= 1'b0;
            err_mag_q   <= '0;
            err_valid_q <= 1'b0;
        end else begin
            err_valid_q <= res_c;
            if (res_c) begin
                err_sign_q <= res_sign_c;
                err_mag_q  <= res_mag_c;
            end
        end
    end

    assign bus.err_sign  = err_sign_q;
    assign bus.err_mag   = err_mag_q;
    assign bus.err_valid = err_valid_q;

`ifdef PFD_LOCK_DETECT_EN
    localparam int unsigned LCW = $clog2(LOCK_CNT + 1);

    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_q, lock_d;

    // Lock decision is taken from the result event so it changes on the
    // same cycle as the corresponding err_valid.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (!enable) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end else if (res_c) begin
            if (res_mag_c <= CNT_W'(LOCK_TOL)) begin
                if (lock_cnt_q != LCW'(LOCK_CNT)) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
                lock_d = (lock_cnt_d == LCW'(LOCK_CNT));
            end else begin
                lock_cnt_d = '0;
                lock_d     = 1'b0;
            end
        end
    end

    // Lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign bus.lock = lock_q;
`endif

endmodule

// File: tb/tb_pfd_tdc_5bit.sv
// Self-checking bench for pfd_tdc_5bit: directed vector table, randomized
// edge pairs against an arithmetic reference model, and hand-written
// sequences for timeout, restart, enable, reset and (optionally) lock.
module tb_pfd_tdc_5bit;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 5;
    localparam int          LAT         = SYNC_STAGES + 1;
    localparam int          NONE        = -100;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic ref_in = 1'b0;
    logic dco_in = 1'b0;

    pfd_tdc_5bit_if #(.CNT_W(CNT_W)) bus ();

    pfd_tdc_5bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .ref_in (ref_in),
        .dco_in (dco_in),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int sign;
        int mag;
        int lk;
    } ev_t;

    typedef struct {
        int d;
        int s;
        int m;
    } vec_t;

    ev_t got[$];
    ev_t mon_e;

    // Capture every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (bus.err_valid === 1'b1) begin
            mon_e.cyc  = cyc;
            mon_e.sign = int'(bus.err_sign);
            mon_e.mag  = int'(bus.err_mag);
`ifdef PFD_LOCK_DETECT_EN
            mon_e.lk   = int'(bus.lock);
`else
            mon_e.lk   = 0;
`endif
            got.push_back(mon_e);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive 2-cycle pulses: ref at offsets r0 and r1, dco at d0 (NONE = no pulse).
    task automatic drive(input int r0, input int r1, input int d0, input int len,
                         output int start);
        start = cyc;
        for (int i = 0; i < len; i++) begin
            ref_in = (i >= r0 && i <= r0 + 1) || (i >= r1 && i <= r1 + 1);
            dco_in = (i >= d0 && i <= d0 + 1);
            @(negedge clk);
        end
        ref_in = 1'b0;
        dco_in = 1'b0;
    endtask

    // Expect exactly one strobe at ecyc with the given result; outputs then hold.
    task automatic check_ev(input string nm, input int ecyc, input int es,
                            input int em, output int lk);
        ev_t e;
        int  n;
        n = got.size();
        chk({nm, "_count"}, n, 1);
        if (n > 0) e = got.pop_front();
        else e = '{cyc: -1, sign: -1, mag: -1, lk: -1};
        chk({nm, "_cyc"}, e.cyc, ecyc);
        chk({nm, "_sign"}, e.sign, es);
        chk({nm, "_mag"}, e.mag, em);
        chk({nm, "_hold_mag"}, int'(bus.err_mag), em);
        chk({nm, "_hold_valid"}, int'(bus.err_valid), 0);
        lk = e.lk;
        got.delete();
    endtask

    // d = dco edge time minus ref edge time, in clk cycles.
    task automatic run_pair(input string nm, input int d, input int es,
                            input int em, output int lk);
        int ra, rd, lead, start;
        ra   = (d < 0) ? -d : 0;
        rd   = (d > 0) ?  d : 0;
        lead = (ra > rd) ? ra : rd;
        drive(ra, NONE, rd, lead + 10, start);
        check_ev(nm, start + lead + LAT, es, em, lk);
    endtask

    vec_t vecs[9];
    int   lk, start, d, es, em, ad;

    initial begin
        vecs = '{'{7, 0, 7}, '{-3, 1, 3}, '{0, 0, 0}, '{1, 0, 1}, '{-1, 1, 1},
                 '{31, 0, 31}, '{-31, 1, 31}, '{12, 0, 12}, '{-20, 1, 20}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_sign", int'(bus.err_sign), 0);
        chk("reset_mag", int'(bus.err_mag), 0);
        chk("reset_valid", int'(bus.err_valid), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_strobe", got.size(), 0);

        // Directed table
        foreach (vecs[i]) begin
            run_pair($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].m, lk);
        end

        // Randomized pairs against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            d  = int'($urandom_range(0, 62)) - 31;
            ad = (d < 0) ? -d : d;
            es = (d < 0) ? 1 : 0;
            em = (ad > 31) ? 31 : ad;
            run_pair($sformatf("rnd%0d_d%0d", i, d), d, es, em, lk);
        end

        // Timeout: ref with no partner
        drive(0, NONE, NONE, 45, start);
        check_ev("timeout", start + 32 + LAT, 0, 31, lk);

        // Restart: ref, ref again 5 later, dco 4 after that
        drive(0, 5, 9, 20, start);
        check_ev("restart", start + 9 + LAT, 0, 4, lk);

        // enable=0: no strobes, outputs hold, no false edge on re-enable
        enable = 1'b0;
        drive(0, NONE, 3, 15, start);
        chk("en0_no_strobe", got.size(), 0);
        chk("en0_hold_mag", int'(bus.err_mag), 4);
        ref_in = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        ref_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("en1_no_false_edge", got.size(), 0);
        run_pair("after_enable", 2, 0, 2, lk);

        // Reset in the middle of a measurement
        drive(0, 4, NONE, 8, start);
        ref_in = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("rst_mid_sign", int'(bus.err_sign), 0);
        chk("rst_mid_mag", int'(bus.err_mag), 0);
        chk("rst_mid_valid", int'(bus.err_valid), 0);
        ref_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_release_no_strobe", got.size(), 0);
        got.delete();
        run_pair("after_reset", -5, 1, 5, lk);

`ifdef PFD_LOCK_DETECT_EN
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            run_pair($sformatf("lock_in%0d", k), 1, 0, 1, lk);
            chk($sformatf("lock_at%0d", k), lk, (k == 7) ? 1 : 0);
        end
        chk("lock_held", int'(bus.lock), 1);
        run_pair("lock_out", 5, 0, 5, lk);
        chk("lock_drop_on_strobe", lk, 0);
        for (int k = 0; k < 8; k++) run_pair($sformatf("relock%0d", k), -1, 1, 1, lk);
        chk("relock", int'(bus.lock), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("lock_en0", int'(bus.lock), 0);
        drive(0, NONE, 1, 12, start);
        chk("lock_en0_no_strobe", got.size(), 0);
        enable = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected end", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pfd_tdc_5bit.md
Name: pfd_tdc_5bit

Overview:
- Digital phase/frequency detector and time-to-digital converter for the ADPLL loop.
- Compares rising edges of the reference clock and the DCO output, both sampled in the system clk domain.
- Produces a 5-bit sign-magnitude phase error plus a one-cycle valid strobe, which the loop filter consumes.
- Sign convention matches the DCO control input: err_sign=1 means the DCO leads and must slow down.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on ref_in and dco_in (minimum 2).
- CNT_W, 5, width of the error magnitude and the internal counter.
- LOCK_TOL, 1, maximum magnitude counted as "in lock" (LOCK_DETECT_EN only).
- LOCK_CNT, 8, consecutive in-tolerance results needed to assert lock (LOCK_DETECT_EN only).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  measurement enable; low forces IDLE.
- ref_in  in  1  reference clock, asynchronous to clk.
- dco_in  in  1  DCO output, treated as asynchronous.
- err_sign  out  1  1 = DCO edge first (DCO leads); 0 = reference first or simultaneous.
- err_mag  out  CNT_W  clk cycles between leading and trailing edge, saturating.
- err_valid  out  1  one-cycle strobe marking a new err_sign/err_mag.
- lock  out  1  lock indicator; present only with LOCK_DETECT_EN.

Behaviour:
- Reset (rst_n=0, async): synchronizers, edge history and counter cleared; FSM to IDLE; err_sign=0, err_mag=0, err_valid=0, lock=0.
- Edge detect: a rise is declared on a cycle where the last sync stage is 1 and its previous value was 0.
  - Latency from input transition to detected rise is SYNC_STAGES+1 clk.
- FSM states: IDLE, WAIT_DCO, WAIT_REF.
  - IDLE, ref_rise only: go to WAIT_DCO, cnt=0.
  - IDLE, dco_rise only: go to WAIT_REF, cnt=0.
  - IDLE, both rise in the same cycle: result sign=0, mag=0; stay in IDLE.
  - WAIT_DCO, each cycle without dco_rise: cnt=cnt+1.
  - WAIT_DCO, dco_rise: result sign=0, mag=min(cnt+1, 31); go to IDLE.
  - WAIT_REF: mirror of WAIT_DCO with ref_rise as the partner edge; result sign=1.
  - Leader edge recurs before the partner (e.g. ref_rise in WAIT_DCO without dco_rise): restart measurement, cnt=0, no result.
    - If leader and partner rise in the same cycle, the partner wins: result issued, go to IDLE.
  - Timeout: cnt reaches 2^CNT_W-1 without a partner edge: result mag=31 with the state's sign; go to IDLE.
- Result timing:
  - err_sign and err_mag are registered and update on the clk edge following the result event.
  - err_valid is high for exactly that one cycle.
  - Outputs hold between results.
- Arithmetic: counter is CNT_W bits with a saturating increment; it never wraps.
- enable=0:
  - FSM goes synchronously to IDLE and cnt is cleared.
  - No err_valid is issued; err outputs hold.
  - Synchronizers and edge history keep running, so no false edge appears when enable rises.
- Reset mid-measurement abandons the measurement immediately; no result is produced.

Optional Feature:
- Macro: PFD_LOCK_DETECT_EN.
- Defined:
  - lock port present.
  - An in-lock counter increments on each err_valid with err_mag<=LOCK_TOL and clears on err_valid with a larger magnitude.
  - lock=1 once the counter reaches LOCK_CNT; the counter saturates there.
  - Any out-of-tolerance result deasserts lock on the same cycle err_valid is high.
  - enable=0 clears the counter and lock.
- Not defined: lock port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package adpll_pkg holds:
  - FSM state typedef (IDLE/WAIT_DCO/WAIT_REF);
  - CNT_W default;
  - ERR_MAX=31;
  - sign encoding constants SIGN_DCO_LEADS=1 and SIGN_DCO_LAGS=0, shared with dco_5bit and the loop filter.
- One sub-module: sync_edge_det, a SYNC_STAGES synchronizer plus rising-edge detector, instantiated twice (ref and dco).

Test Plan:
- Reset: rst_n low mid-WAIT_DCO with toggling inputs -> all outputs 0 immediately; no err_valid after release until a fresh edge pair.
- Reference leads: ref rise, dco rise 7 clk later -> one err_valid, err_sign=0, err_mag=7; outputs hold afterwards.
- DCO leads: dco rise, ref rise 3 clk later -> err_sign=1, err_mag=3.
- Simultaneous: both inputs rise in the same clk cycle -> err_sign=0, err_mag=0, err_valid pulse.
- Timeout and restart: ref rise with no dco for 40 clk -> err_mag=31, err_sign=0 at timeout. Ref, then ref again 5 clk later, then dco 4 clk after that -> err_mag=4.
- Lock (PFD_LOCK_DETECT_EN): 8 results of mag 1 -> lock=1 on the 8th strobe; next result mag 5 -> lock=0. enable=0 -> lock=0 and no strobes.
